fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 instr_in  input  32  instruction word from instruction memory, combinationally addressed by pc_out.
REQ-005 branch_taken  input  1  Branch AND Zero from the decode/ALU path, qualifies branch_target.
REQ-006 branch_target  input  32  PC+4 plus shifted sign-extended offset.
REQ-007 jump  input  1  Jump control for the instruction held in IF/ID.
REQ-008 jump_target  input  32  {pc4[31:28], target, 2'b00}.
REQ-009 stall  input  1  hold request from downstream.
REQ-010 halt_req  input  1  stop fetching permanently until reset.
REQ-011 pc_out  output  32  current fetch address, drives instruction memory address input.
REQ-012 if_id_instr  output  32  registered fetched instruction.
REQ-013 if_id_pc4  output  32  registered fetch address + 4.
REQ-014 if_id_valid  output  1  IF/ID contents are a live instruction.
REQ-015 misalign_err  output  1  sticky flag, redirect target not word-aligned.
REQ-016 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STALLED, 3 HALTED.

Function
REQ-017 FSM SHALL have states IDLE, RUN, STALLED, HALTED; IDLE lasts exactly one cycle after reset, then RUN.
REQ-018 In IDLE no fetch is latched: if_id_valid stays 0, pc_out holds RESET_PC.
REQ-019 In RUN with no event: if_id_instr<=instr_in, if_id_pc4<=pc_out+4, if_id_valid<=1, pc_out<=pc_out+4.
REQ-020 PC arithmetic SHALL be modulo 2^32; pc_out 32'hFFFFFFFC advances to 32'h00000000 without error.
REQ-021 Redirect = (jump OR branch_taken) AND if_id_valid; jump/branch_taken with if_id_valid=0 SHALL be ignored.
REQ-022 Target select: jump_target if jump=1, else branch_target (jump wins when both asserted).
REQ-023 On redirect with aligned target: pc_out<=target, if_id_valid<=0 (squash wrong-path fetch; one-cycle bubble), state RUN.
REQ-024 On redirect with target[1:0]!=0: misalign_err<=1, if_id_valid<=0, pc_out unchanged, state<=HALTED.
REQ-025 stall=1 in RUN (no redirect): pc_out, if_id_instr, if_id_pc4, if_id_valid hold; state<=STALLED.
REQ-026 In STALLED: hold all registers while stall=1; on stall=0 return to RUN and resume fetch next cycle from held pc_out.
REQ-027 Redirect SHALL take priority over stall in RUN and STALLED; applies per REQ-023/024 and state<=RUN (or HALTED).
REQ-028 halt_req=1 in IDLE/RUN/STALLED: state<=HALTED, if_id_valid<=0, pc_out holds; halt_req beats redirect and stall.
REQ-029 HALTED SHALL be exited only by reset; all inputs except reset ignored; outputs hold.
REQ-030 Overall priority: reset > halt_req > redirect > stall > sequential fetch.
REQ-031 Fetch latency: instruction at pc_out appears on if_id_instr with if_id_valid=1 one cycle later.

Reset
REQ-032 reset=1 at a rising edge SHALL, regardless of state, set pc_out=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, misalign_err=0, state=IDLE.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; no partial update survives.

Verification
REQ-034 Reset, then 4 free cycles with imem returning addr-tagged words -> pc_out 0,0,4,8,12; if_id_valid 0,0,1,1,1; if_id_pc4 4,8,12 on valid cycles.
REQ-035 jump=1, jump_target=0x40 while if_id_valid=1 at pc_out=0x10 -> next pc_out=0x40, if_id_valid=0 one cycle, then instr at 0x40 valid.
REQ-036 stall=1 for 3 cycles at pc_out=0x8 -> pc_out/IF-ID frozen, state=2; stall=0 -> state=1, pc_out 0xC next cycle.
REQ-037 branch_taken=1, branch_target=0x22 -> misalign_err=1, state=3, pc_out unchanged; further stimuli ignored until reset clears all.
REQ-038 stall=1 and branch_taken=1 (target 0x80) same cycle -> pc_out=0x80, state=1; halt_req with jump same cycle -> state=3, pc_out unchanged.
REQ-039 RESET_PC=32'hFFFFFFF8, run 3 cycles -> pc_out FFFFFFF8, FFFFFFFC, 00000000, misalign_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register and a small control FSM.
//
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   reset         - synchronous active-high reset
//   instr_in      - instruction word from instruction memory, addressed by pc_out
//   branch_taken  - Branch AND Zero from decode/ALU, qualifies branch_target
//   branch_target - branch destination address
//   jump          - jump control for the instruction held in IF/ID
//   jump_target   - jump destination address
//   stall         - hold request from downstream
//   halt_req      - stop fetching until reset
//   pc_out        - current fetch address
//   if_id_instr   - registered fetched instruction
//   if_id_pc4     - registered fetch address + 4
//   if_id_valid   - IF/ID holds a live instruction
//   misalign_err  - sticky flag, redirect target was not word-aligned
//   state         - FSM state: 0 IDLE, 1 RUN, 2 STALLED, 3 HALTED
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        halt_req,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StStalled = 2'd2,
    StHalted  = 2'd3
  } stateT;

  stateT       stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] instrReg, instrNext;
  logic [31:0] pc4Reg, pc4Next;
  logic        validReg, validNext;
  logic        errReg, errNext;

  logic        redirect;
  logic [31:0] target;
  logic        misaligned;
  logic [31:0] pcPlus4;

  // A redirect only counts when the instruction that requested it is live.
  assign redirect   = (jump | branch_taken) & validReg;
  assign target     = jump ? jump_target : branch_target;
  assign misaligned = (target[1:0] != 2'b00);
  assign pcPlus4    = pcReg + 32'd4;  // wraps modulo 2^32

  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    instrNext = instrReg;
    pc4Next   = pc4Reg;
    validNext = validReg;
    errNext   = errReg;

    unique case (stateReg)
      StIdle: begin
        if (halt_req) begin
          stateNext = StHalted;
          validNext = 1'b0;
        end else begin
          stateNext = StRun;
        end
      end

      StRun, StStalled: begin
        if (halt_req) begin
          stateNext = StHalted;
          validNext = 1'b0;
        end else if (redirect) begin
          // Squash the wrong-path fetch currently entering IF/ID.
          validNext = 1'b0;
          if (misaligned) begin
            errNext   = 1'b1;
            stateNext = StHalted;
          end else begin
            pcNext    = target;
            stateNext = StRun;
          end
        end else if (stall) begin
          stateNext = StStalled;
        end else if (stateReg == StRun) begin
          instrNext = instr_in;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
          pcNext    = pcPlus4;
        end else begin
          // Leaving STALLED: fetch resumes from the held PC next cycle.
          stateNext = StRun;
        end
      end

      StHalted: begin
        // Only reset leaves this state.
      end

      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= StIdle;
      pcReg    <= RESET_PC;
      instrReg <= 32'h0;
      pc4Reg   <= 32'h0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      instrReg <= instrNext;
      pc4Reg   <= pc4Next;
      validReg <= validNext;
      errReg   <= errNext;
    end
  end

  assign pc_out       = pcReg;
  assign if_id_instr  = instrReg;
  assign if_id_pc4    = pc4Reg;
  assign if_id_valid  = validReg;
  assign misalign_err = errReg;
  assign state        = stateReg;

endmodule
